// File: rtl/elevator_car_controller.sv
// elevator_car_controller: per-car sequencer that queues floor calls, steps the car
// one floor at a time and opens the doors at requested floors.
//   clk               in   clock, rising edge
//   rst               in   asynchronous active-high reset
//   call_valid        in   one-cycle floor call strobe
//   call_floor        in   floor index of the call
//   res_queue_empty   in   resolver: no pending requests
//   res_next_up_ndown in   resolver: 1=up, 0=down
//   queue_status      out  pending requests, bit i = floor i
//   current_floor     out  car position
//   current_up_ndown  out  last committed direction
//   moving            out  motor enable (MOVE)
//   door_open         out  door command (DOOR)
//   arrived           out  one-cycle pulse when a stop is served
module elevator_car_controller #(
    parameter int NUM_FLOORS    = 7,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  call_valid,
    input  logic [2:0]            call_floor,
    input  logic                  res_queue_empty,
    input  logic                  res_next_up_ndown,
    output logic [NUM_FLOORS-1:0] queue_status,
    output logic [2:0]            current_floor,
    output logic                  current_up_ndown,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrived
);
    localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LD   = TW'(DOOR_CYCLES - 1);
    localparam logic [2:0] TOP = 3'(NUM_FLOORS - 1);
    localparam logic [3:0] NF  = 4'(NUM_FLOORS);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DECIDE = 2'd1;
    localparam logic [1:0] MOVE   = 2'd2;
    localparam logic [1:0] DOOR   = 2'd3;

    logic [1:0]            r_state, w_state;
    logic [TW-1:0]         r_timer, w_timer;
    logic [NUM_FLOORS-1:0] r_queue, w_set, w_clr;
    logic [2:0]            r_floor, w_floor, w_step_floor;
    logic                  r_dir, w_dir;
    logic                  r_moving, r_door, r_arrived, w_arrived;
    logic                  w_here_call, w_move_blocked, w_res_blocked;

    // A call for the floor the car is standing at (doors closed or open) is served by
    // the door directly and never enters the queue.
    assign w_here_call    = call_valid && call_floor == r_floor && (r_state == IDLE || r_state == DOOR);
    assign w_set          = (call_valid && {1'b0, call_floor} < NF && !w_here_call) ? NUM_FLOORS'(1) << call_floor : '0;
    assign w_step_floor   = r_dir ? r_floor + 3'd1 : r_floor - 3'd1;
    assign w_move_blocked = r_dir ? r_floor == TOP : r_floor == 3'd0;
    assign w_res_blocked  = res_next_up_ndown ? r_floor == TOP : r_floor == 3'd0;

    always_comb begin
        w_state   = r_state;
        w_timer   = r_timer;
        w_floor   = r_floor;
        w_dir     = r_dir;
        w_clr     = '0;
        w_arrived = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_here_call) begin
                    w_state = DOOR;
                    w_timer = DOOR_LD;
                end else if (!res_queue_empty) begin
                    w_state = DECIDE;
                end
            end
            DECIDE: begin
                if (r_queue != '0) w_dir = res_next_up_ndown;
                if (r_queue[r_floor]) begin
                    w_clr     = NUM_FLOORS'(1) << r_floor;
                    w_arrived = 1'b1;
                    w_state   = DOOR;
                    w_timer   = DOOR_LD;
                end else if (r_queue == '0 || w_res_blocked) begin
                    // A direction that would step off the shaft is refused; IDLE retries.
                    w_state = IDLE;
                end else begin
                    w_state = MOVE;
                    w_timer = TRAVEL_LD;
                end
            end
            MOVE: begin
                if (r_timer != '0) begin
                    w_timer = r_timer - 1'b1;
                end else if (w_move_blocked) begin
                    w_state = DECIDE;
                end else begin
                    w_floor = w_step_floor;
                    if (r_queue[w_step_floor]) begin
                        w_clr     = NUM_FLOORS'(1) << w_step_floor;
                        w_arrived = 1'b1;
                        w_state   = DOOR;
                        w_timer   = DOOR_LD;
                    end else begin
                        w_timer = TRAVEL_LD;
                    end
                end
            end
            default: begin
                if (w_here_call) begin
                    w_timer = DOOR_LD;
                end else if (r_timer != '0) begin
                    w_timer = r_timer - 1'b1;
                end else begin
                    w_state = DECIDE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_queue   <= '0;
            r_floor   <= 3'd0;
            r_dir     <= 1'b1;
            r_moving  <= 1'b0;
            r_door    <= 1'b0;
            r_arrived <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_timer   <= w_timer;
            // Clear after set: a call for a floor being served this cycle is dropped.
            r_queue   <= (r_queue | w_set) & ~w_clr;
            r_floor   <= w_floor;
            r_dir     <= w_dir;
            r_moving  <= w_state == MOVE;
            r_door    <= w_state == DOOR;
            r_arrived <= w_arrived;
        end
    end

    assign queue_status     = r_queue;
    assign current_floor    = r_floor;
    assign current_up_ndown = r_dir;
    assign moving           = r_moving;
    assign door_open        = r_door;
    assign arrived          = r_arrived;
endmodule

// File: tb/tb_elevator_car_controller.sv
module tb_elevator_car_controller;
    logic       clk, rst, call_valid, res_queue_empty, res_next_up_ndown;
    logic [2:0] call_floor, current_floor;
    logic [6:0] queue_status, above, below;
    logic       current_up_ndown, moving, door_open, arrived;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { int fl; int cyc; } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct { int fl; bit arr; int lat; int door_end; int qexp; int end_fl; } vec_t;
    vec_t vecs[7];

    elevator_car_controller #(.NUM_FLOORS(7), .TRAVEL_CYCLES(8), .DOOR_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .call_valid(call_valid), .call_floor(call_floor),
        .res_queue_empty(res_queue_empty), .res_next_up_ndown(res_next_up_ndown),
        .queue_status(queue_status), .current_floor(current_floor),
        .current_up_ndown(current_up_ndown), .moving(moving), .door_open(door_open),
        .arrived(arrived)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Resolver: keep going while requests lie ahead, otherwise reverse.
    always_comb begin
        above = '0;
        below = '0;
        for (int i = 0; i < 7; i++) begin
            if (i > int'(current_floor)) above[i] = queue_status[i];
            if (i < int'(current_floor)) below[i] = queue_status[i];
        end
        res_queue_empty   = (queue_status == 7'd0);
        res_next_up_ndown = current_up_ndown ? (above != 7'd0 || below == 7'd0) : (below == 7'd0 && above != 7'd0);
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cyc %0d", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("moving_and_door", int'(moving && door_open), 0);
            if (arrived) begin
                if (sb.size() == 0) begin
                    chk("unexpected_arrival_floor", int'(current_floor), -1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("arrive_floor", int'(current_floor), mon_e.fl);
                    chk("arrive_cyc", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic call(input int f, output int cap);
        call_valid = 1'b1;
        call_floor = 3'(f);
        cap = cyc + 1;
        @(negedge clk);
        call_valid = 1'b0;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drain", sb.size(), 0);
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_door_end(input string name, input int cap, input int door_end);
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (door_open) seen = 1;
            else if (seen) break;
            @(negedge clk);
        end
        chk(name, cyc - cap, door_end);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c, c2, x;
        vecs[0] = '{5, 1'b1, 42, 58, 32, 5};
        vecs[1] = '{7, 1'b0, 0, 0, 0, 5};
        vecs[2] = '{5, 1'b0, 0, 16, 0, 5};
        vecs[3] = '{0, 1'b1, 42, 58, 1, 0};
        vecs[4] = '{6, 1'b1, 50, 66, 64, 6};
        vecs[5] = '{3, 1'b1, 26, 42, 8, 3};
        vecs[6] = '{4, 1'b1, 10, 26, 16, 4};

        rst = 1'b1;
        call_valid = 1'b0;
        call_floor = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_floor", int'(current_floor), 0);
        chk("rst_queue", int'(queue_status), 0);
        chk("rst_dir", int'(current_up_ndown), 1);
        chk("rst_moving", int'(moving), 0);
        chk("rst_door", int'(door_open), 0);
        chk("rst_arrived", int'(arrived), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: floor 0 -> 3
        sb.push_back('{3, cyc + 1 + 26});
        call(3, c);
        chk("t1_queue", int'(queue_status), 8);
        wait_to(c + 1);
        chk("t1_decide_not_moving", int'(moving), 0);
        wait_to(c + 2);
        chk("t1_move_entry", int'(moving), 1);
        wait_to(c + 9);
        chk("t1_floor_c9", int'(current_floor), 0);
        wait_to(c + 10);
        chk("t1_floor_c10", int'(current_floor), 1);
        wait_to(c + 18);
        chk("t1_floor_c18", int'(current_floor), 2);
        wait_to(c + 26);
        chk("t1_floor_c26", int'(current_floor), 3);
        chk("t1_door_open", int'(door_open), 1);
        chk("t1_queue_cleared", int'(queue_status), 0);
        wait_door_end("t1_door_end", c, 42);
        repeat (2) @(negedge clk);
        chk("t1_idle_moving", int'(moving), 0);
        chk("t1_dir", int'(current_up_ndown), 1);
        drain();

        // 2: at 3 going up, calls 5 and 1
        sb.push_back('{5, cyc + 1 + 18});
        sb.push_back('{1, cyc + 1 + 67});
        call(5, c);
        call(1, c2);
        chk("t2_queue", int'(queue_status), 34);
        drain();
        chk("t2_floor", int'(current_floor), 1);
        chk("t2_queue_empty", int'(queue_status), 0);
        chk("t2_dir_down", int'(current_up_ndown), 0);

        // 3: idle at 2, call 2 opens door without queueing; repeat call extends it
        sb.push_back('{2, cyc + 1 + 10});
        call(2, c);
        drain();
        call(2, c);
        chk("t3_door", int'(door_open), 1);
        chk("t3_queue", int'(queue_status), 0);
        chk("t3_arrived", int'(arrived), 0);
        wait_to(c + 9);
        call(2, c2);
        chk("t3_queue_2", int'(queue_status), 0);
        wait_door_end("t3_door_extended", c, 26);
        repeat (3) @(negedge clk);
        chk("t3_floor", int'(current_floor), 2);

        // 4: 0 -> 4 with an intermediate call at 2, floor 7 ignored
        sb.push_back('{0, cyc + 1 + 18});
        call(0, c);
        drain();
        sb.push_back('{4, cyc + 1 + 51});
        call(4, c);
        wait_to(c + 4);
        sb.push_front('{2, c + 18});
        call(2, x);
        call(7, x);
        chk("t4_queue", int'(queue_status), 20);
        chk("t4_moving", int'(moving), 1);
        chk("t4_floor", int'(current_floor), 0);
        drain();
        chk("t4_end_floor", int'(current_floor), 4);
        chk("t4_end_queue", int'(queue_status), 0);

        // 6: call at the arriving floor in the clear cycle
        sb.push_back('{6, cyc + 1 + 18});
        call(6, c);
        wait_to(c + 17);
        call(6, c2);
        chk("t6_clear_wins", int'(queue_status), 0);
        chk("t6_floor", int'(current_floor), 6);
        drain();
        chk("t6_end_queue", int'(queue_status), 0);
        chk("t6_end_door", int'(door_open), 0);

        // 5: reset mid-move
        call(2, c);
        wait_to(c + 13);
        chk("t5_mid_moving", int'(moving), 1);
        chk("t5_mid_floor", int'(current_floor), 5);
        rst = 1'b1;
        #1;
        chk("t5_rst_floor", int'(current_floor), 0);
        chk("t5_rst_queue", int'(queue_status), 0);
        chk("t5_rst_moving", int'(moving), 0);
        chk("t5_rst_dir", int'(current_up_ndown), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("t5_after_floor", int'(current_floor), 0);
        chk("t5_after_moving", int'(moving), 0);

        for (int k = 0; k < 7; k++) begin
            if (vecs[k].arr) sb.push_back('{vecs[k].fl, cyc + 1 + vecs[k].lat});
            call(vecs[k].fl, c);
            chk($sformatf("v%0d_queue", k), int'(queue_status), vecs[k].qexp);
            if (vecs[k].door_end != 0) wait_door_end($sformatf("v%0d_door_end", k), c, vecs[k].door_end);
            else repeat (10) @(negedge clk);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_floor", k), int'(current_floor), vecs[k].end_fl);
            chk($sformatf("v%0d_end_queue", k), int'(queue_status), 0);
            chk($sformatf("v%0d_end_moving", k), int'(moving), 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
